// File: rtl/mxu_feeder_pkg.sv
// mxu_feeder_pkg: shared precision, stream-word and sequencer state definitions
package mxu_feeder_pkg;
  localparam int PREC_W = 4;
  localparam int STREAM_W = 64;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} feeder_state_t;
endpackage

// File: rtl/mxu_feeder_valid_tracker.sv
// valid_tracker: enable-gated shift register marking real vectors travelling through the MXU pipeline
module valid_tracker #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  output logic tail
);
  logic [DEPTH-1:0] sr;
  always_ff @(posedge clk or posedge reset)
    if (reset) sr <= '0;
    else if (en) sr <= (sr << 1) | DEPTH'(din);
  assign tail = sr[DEPTH-1];
endmodule

// File: rtl/mxu_feeder.sv
// mxu_feeder: stream-side sequencer feeding vectors and lock-step enables into the skewed MXU
module mxu_feeder import mxu_feeder_pkg::*; #(
  parameter int M = 3,
  parameter int K = 3,
  parameter int max_data_width = PREC_W,
  parameter int PIPE_LAT = M + K - 1,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CNT_W-1:0]            num_vectors,
  input  logic [STREAM_W-1:0]         s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [K*max_data_width-1:0] input_data,
  output logic                        enable,
  output logic                        enable_in_ff,
  output logic                        enable_chain,
  output logic                        enable_out_ff,
  output logic                        y_valid,
  output logic                        busy,
  output logic                        done
);
  localparam int DW = K * max_data_width;
  localparam int DCW = $clog2(PIPE_LAT + 1);
  feeder_state_t state;
  logic [CNT_W-1:0] nv, issued;
  logic [DCW-1:0] dcnt;
  logic adv, live, tail, fire, unused_bits;
  assign s_ready = state == STREAM;
  assign busy = state == STREAM || state == DRAIN;
  assign fire = s_valid & s_ready;
  assign enable = adv;
  assign enable_in_ff = adv;
  assign enable_chain = adv;
  assign enable_out_ff = adv;
  assign y_valid = adv & tail;
  assign unused_bits = ^s_data;
  // DRAIN lasts one cycle longer than its PIPE_LAT bubbles so done lands after the last advance
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      nv <= '0;
      issued <= '0;
      dcnt <= '0;
      adv <= 1'b0;
      live <= 1'b0;
      done <= 1'b0;
      input_data <= '0;
    end else begin
      adv <= 1'b0;
      live <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          nv <= num_vectors;
          issued <= '0;
          dcnt <= '0;
          state <= num_vectors == '0 ? DONE : STREAM;
          done <= num_vectors == '0;
        end
        STREAM: if (fire) begin
          input_data <= s_data[DW-1:0];
          issued <= issued + 1'b1;
          adv <= 1'b1;
          live <= 1'b1;
          if (issued == nv - 1'b1) state <= DRAIN;
        end
        DRAIN: begin
          input_data <= '0;
          adv <= dcnt < DCW'(PIPE_LAT);
          dcnt <= dcnt + 1'b1;
          if (dcnt == DCW'(PIPE_LAT)) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  valid_tracker #(.DEPTH(PIPE_LAT)) u_tracker (
    .clk(clk),
    .reset(reset),
    .en(adv),
    .din(live),
    .tail(tail)
  );
endmodule
